// File: rtl/ahb2apb_bridge_core.sv
// rtl/ahb2apb_bridge_core.sv - AHB-Lite slave to APB master bridge; optional ACCESS timeout under APB_TIMEOUT_EN
module ahb2apb_bridge_core #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WLATCH = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR1   = 3'd5;
  localparam logic [2:0] S_ERR2   = 3'd6;

  logic [2:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] paddr_q,  paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  accept;
  logic                  timed_out;

  // HTRANS[0] only distinguishes NONSEQ from SEQ; both are handled identically
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Bus-facing handshake outputs decode straight from the registered state
  assign HREADY  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign HRESP   = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE = (state_q == S_ACCESS);
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign HRDATA  = hrdata_q;

  assign accept = HSEL && HTRANS[1] && HREADY;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Wait counter: zeroed in SETUP so it starts clean on ACCESS entry
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_SETUP) begin
      tmo_d = '0;
    end else if ((state_q == S_ACCESS) && !PREADY) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  // Limit is hit when this waiting cycle would bring the count to TIMEOUT_CYCLES
  assign timed_out = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timed_out      = 1'b0;
`endif

  // Transfer sequencing and capture of address, write data and read data
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          state_d  = HWRITE ? S_WLATCH : S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WLATCH: begin
        pwdata_d = HWDATA;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_d = S_ERR1;
          end else begin
            if (!pwrite_q) begin
              hrdata_d = PRDATA;
            end
            state_d = S_DONE;
          end
        end else if (timed_out) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_core.sv
// tb/tb_ahb2apb_bridge_core.sv - self-checking bench for ahb2apb_bridge_core
module tb_ahb2apb_bridge_core;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, PREADY, PSLVERR;
  logic [1:0]    HTRANS;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA, PRDATA;
  logic          HREADY, HRESP, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] HRDATA, PWDATA;
  logic [AW-1:0] PADDR;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: what the APB-side registers and HRDATA should currently hold
  logic [AW-1:0] exp_paddr;
  logic          exp_pwrite;
  logic [DW-1:0] exp_pwdata;
  logic [DW-1:0] exp_hrdata;

  always #5 HCLK = ~HCLK;

  ahb2apb_bridge_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Expected {HREADY,HRESP,PSEL,PENABLE} in cycle k after the accepting edge
  function automatic logic [3:0] exp_ctl(int k, int w, int n, bit err);
    if (k <= w)         return 4'b0000;
    if (k == w + 1)     return 4'b0010;
    if (k <= w + 2 + n) return 4'b0011;
    if (k == w + 3 + n) return err ? 4'b0100 : 4'b1000;
    return 4'b1100;
  endfunction

  task automatic test_reset();
    HRESET = 1; HSEL = 0; HTRANS = 2'b00; HADDR = '0; HWRITE = 0; HWDATA = '0;
    PRDATA = '0; PREADY = 0; PSLVERR = 0;
    tick(); tick();
    n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== 4'b1000) $display("FAIL reset_ctl: got %b want 1000", {HREADY, HRESP, PSEL, PENABLE}); else n_pass++;
    n_total++; if ({PADDR, PWRITE, PWDATA, HRDATA} !== '0) $display("FAIL reset_data: got paddr=%h pwrite=%b pwdata=%h hrdata=%h want all 0", PADDR, PWRITE, PWDATA, HRDATA); else n_pass++;
    HRESET = 0;
    exp_paddr = '0; exp_pwrite = 0; exp_pwdata = '0; exp_hrdata = '0;
    tick();
    n_total++; if ({HREADY, HRESP, PSEL} !== 3'b100) $display("FAIL reset_idle: got %b want 100", {HREADY, HRESP, PSEL}); else n_pass++;
  endtask

  task automatic test_read();
    HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0010; HWRITE = 0;
    PREADY = 1; PSLVERR = 0; PRDATA = 32'hDEADBEEF;
    tick();
    HSEL = 0; HTRANS = 2'b00;
    n_total++; if ({PSEL, PENABLE, HREADY} !== 3'b100 || PADDR !== 16'h0010) $display("FAIL read_setup: got sel/en/rdy=%b paddr=%h want 100 0010", {PSEL, PENABLE, HREADY}, PADDR); else n_pass++;
    tick();
    n_total++; if ({PSEL, PENABLE, HREADY} !== 3'b110) $display("FAIL read_access: got sel/en/rdy=%b want 110", {PSEL, PENABLE, HREADY}); else n_pass++;
    tick();
    n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== 4'b1000 || HRDATA !== 32'hDEADBEEF) $display("FAIL read_done: got ctl=%b hrdata=%h want 1000 deadbeef", {HREADY, HRESP, PSEL, PENABLE}, HRDATA); else n_pass++;
    exp_paddr = 16'h0010; exp_pwrite = 0; exp_hrdata = 32'hDEADBEEF;
    tick();
    n_total++; if ({HREADY, PSEL} !== 2'b10 || HRDATA !== 32'hDEADBEEF) $display("FAIL read_idle: got rdy/sel=%b hrdata=%h want 10 deadbeef", {HREADY, PSEL}, HRDATA); else n_pass++;
  endtask

  task automatic test_write_wait();
    int pen_cnt;
    pen_cnt = 0;
    HSEL = 1; HTRANS = 2'b11; HADDR = 16'h0024; HWRITE = 1; PREADY = 0; PSLVERR = 1;
    tick();
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hA5A50001;
    for (int k = 1; k <= 6; k++) begin
      n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== exp_ctl(k, 1, 2, 0)) $display("FAIL write_ctl k=%0d: got %b want %b", k, {HREADY, HRESP, PSEL, PENABLE}, exp_ctl(k, 1, 2, 0)); else n_pass++;
      if (k >= 2) begin
        n_total++; if (PWDATA !== 32'hA5A50001 || PWRITE !== 1'b1 || PADDR !== 16'h0024) $display("FAIL write_hold k=%0d: got pwdata=%h pwrite=%b paddr=%h want a5a50001 1 0024", k, PWDATA, PWRITE, PADDR); else n_pass++;
      end
      pen_cnt += int'(PENABLE);
      if (k == 2) HWDATA = $urandom;
      PREADY  = (k == 5);
      PSLVERR = (k != 5);
      if (k < 6) tick();
    end
    n_total++; if (pen_cnt !== 3) $display("FAIL write_penable_cycles: got %0d want 3", pen_cnt); else n_pass++;
    exp_paddr = 16'h0024; exp_pwrite = 1; exp_pwdata = 32'hA5A50001;
    PSLVERR = 0; PREADY = 0;
    tick();
  endtask

  task automatic test_error();
    HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0030; HWRITE = 0;
    PREADY = 1; PSLVERR = 1; PRDATA = 32'h12345678;
    tick();
    HSEL = 0; HTRANS = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== exp_ctl(k, 0, 0, 1)) $display("FAIL err_ctl k=%0d: got %b want %b", k, {HREADY, HRESP, PSEL, PENABLE}, exp_ctl(k, 0, 0, 1)); else n_pass++;
      if (k < 4) tick();
    end
    n_total++; if (HRDATA !== exp_hrdata) $display("FAIL err_hrdata_kept: got %h want %h", HRDATA, exp_hrdata); else n_pass++;
    exp_paddr = 16'h0030; exp_pwrite = 0;
    PSLVERR = 0;
    tick();
    n_total++; if ({HREADY, HRESP} !== 2'b10) $display("FAIL err_recover: got rdy/resp=%b want 10", {HREADY, HRESP}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0004; HWRITE = 1; PREADY = 1; PSLVERR = 0;
    tick();
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hC0FFEE04;
    tick(); tick();
    n_total++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL b2b_w_access: got sel/en=%b want 11", {PSEL, PENABLE}); else n_pass++;
    tick();
    n_total++; if ({HREADY, PSEL} !== 2'b10) $display("FAIL b2b_done_gap: got rdy/sel=%b want 10", {HREADY, PSEL}); else n_pass++;
    HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0008; HWRITE = 0; PRDATA = 32'h0BADF00D;
    tick();
    HSEL = 0; HTRANS = 2'b00;
    n_total++; if (PSEL !== 1'b1 || PADDR !== 16'h0008 || PWRITE !== 1'b0) $display("FAIL b2b_r_setup: got sel=%b paddr=%h pwrite=%b want 1 0008 0", PSEL, PADDR, PWRITE); else n_pass++;
    tick(); tick();
    n_total++; if (HREADY !== 1'b1 || HRDATA !== 32'h0BADF00D || PWDATA !== 32'hC0FFEE04) $display("FAIL b2b_r_done: got rdy=%b hrdata=%h pwdata=%h want 1 0badf00d c0ffee04", HREADY, HRDATA, PWDATA); else n_pass++;
    exp_paddr = 16'h0008; exp_pwrite = 0; exp_pwdata = 32'hC0FFEE04; exp_hrdata = 32'h0BADF00D;
    PREADY = 0;
    tick();
  endtask

  task automatic test_random(int ntr);
    int w, n, last, gap;
    bit err;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [3:0] ec;
    for (int t = 0; t < ntr; t++) begin
      w = $urandom_range(0, 1); n = $urandom_range(0, 3); err = ($urandom_range(0, 3) == 0);
      a = AW'($urandom); wd = $urandom; rd = $urandom;
      last = w + 3 + n + int'(err);
      gap = $urandom_range(0, 2);
      HSEL = 1; HTRANS = {1'b1, 1'($urandom_range(0, 1))}; HADDR = a; HWRITE = (w == 1);
      tick();
      HSEL = 1'($urandom_range(0, 1)); HTRANS = {1'b0, 1'($urandom_range(0, 1))};
      HADDR = AW'($urandom); HWRITE = 1'($urandom_range(0, 1));
      HWDATA = (w == 1) ? wd : $urandom;
      exp_paddr = a; exp_pwrite = (w == 1);
      for (int k = 1; k <= last; k++) begin
        if (w == 1 && k == 2) exp_pwdata = wd;
        if (w == 0 && !err && k == n + 3) exp_hrdata = rd;
        ec = exp_ctl(k, w, n, err);
        n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== ec) $display("FAIL rnd_ctl t=%0d k=%0d: got %b want %b", t, k, {HREADY, HRESP, PSEL, PENABLE}, ec); else n_pass++;
        n_total++; if ({PADDR, PWRITE, PWDATA, HRDATA} !== {exp_paddr, exp_pwrite, exp_pwdata, exp_hrdata}) $display("FAIL rnd_data t=%0d k=%0d: got %h %b %h %h want %h %b %h %h", t, k, PADDR, PWRITE, PWDATA, HRDATA, exp_paddr, exp_pwrite, exp_pwdata, exp_hrdata); else n_pass++;
        if (k == 2) HWDATA = $urandom;
        if (k == w + 2 + n) begin
          PREADY = 1; PSLVERR = err; PRDATA = rd;
        end else if (k >= w + 2 && k < w + 2 + n) begin
          PREADY = 0; PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
        end else begin
          PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
        end
        if (k < last) tick();
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        n_total++; if ({HREADY, HRESP, PSEL, PENABLE, PADDR, PWRITE, HRDATA} !== {4'b1000, exp_paddr, exp_pwrite, exp_hrdata}) $display("FAIL rnd_idle t=%0d: got ctl=%b paddr=%h hrdata=%h want 1000 %h %h", t, {HREADY, HRESP, PSEL, PENABLE}, PADDR, HRDATA, exp_paddr, exp_hrdata); else n_pass++;
      end
    end
    HSEL = 0; HTRANS = 2'b00; PREADY = 0; PSLVERR = 0;
    tick();
  endtask

  task automatic test_reset_midflight();
    HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0040; HWRITE = 0; PREADY = 0;
    tick();
    HSEL = 0; HTRANS = 2'b00;
    tick();
    n_total++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL rst_pre_access: got sel/en=%b want 11", {PSEL, PENABLE}); else n_pass++;
    HRESET = 1;
    tick();
    HRESET = 0;
    n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== 4'b1000 || PADDR !== '0 || HRDATA !== '0) $display("FAIL rst_midflight: got ctl=%b paddr=%h hrdata=%h want 1000 0000 0", {HREADY, HRESP, PSEL, PENABLE}, PADDR, HRDATA); else n_pass++;
    exp_paddr = '0; exp_pwrite = 0; exp_pwdata = '0; exp_hrdata = '0;
    HSEL = 1; HTRANS = 2'b01; HADDR = 16'h0050; PREADY = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if ({PSEL, HREADY} !== 2'b01 || PADDR !== '0) $display("FAIL busy_ignored i=%0d: got sel/rdy=%b paddr=%h want 01 0000", i, {PSEL, HREADY}, PADDR); else n_pass++;
    end
    HSEL = 0; HTRANS = 2'b00; PREADY = 0;
  endtask

  task automatic test_timeout();
    HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0060; HWRITE = 0; PREADY = 0;
    tick();
    HSEL = 0; HTRANS = 2'b00;
`ifdef APB_TIMEOUT_EN
    for (int k = 1; k <= TMO + 3; k++) begin
      n_total++; if ({HREADY, HRESP, PSEL, PENABLE} !== exp_ctl(k, 0, TMO - 1, 1)) $display("FAIL timeout_ctl k=%0d: got %b want %b", k, {HREADY, HRESP, PSEL, PENABLE}, exp_ctl(k, 0, TMO - 1, 1)); else n_pass++;
      if (k < TMO + 3) tick();
    end
`else
    for (int k = 1; k <= 101; k++) tick();
    n_total++; if ({HREADY, PSEL, PENABLE} !== 3'b011) $display("FAIL no_timeout_wait: got rdy/sel/en=%b want 011", {HREADY, PSEL, PENABLE}); else n_pass++;
`endif
    HRESET = 1;
    tick();
    HRESET = 0;
    exp_paddr = '0; exp_pwrite = 0; exp_pwdata = '0; exp_hrdata = '0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_error();
    test_back_to_back();
    test_random(40);
    test_reset_midflight();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge_core.md
Name: ahb2apb_bridge_core

Overview:
- Synthesizable AHB-Lite slave to APB master bridge. It is the design under test that sits downstream of the AHB master interface in the bridge VIP.
- It accepts single AHB transfers on HADDR/HWRITE/HWDATA, runs each one as an APB SETUP/ACCESS sequence, and returns HRDATA/HREADY/HRESP to the AHB side.
- Bridge is the only AHB slave: its HREADY output is also the bus ready.

Parameters:
- ADDR_WIDTH, 16, width of HADDR and PADDR
- DATA_WIDTH, 32, width of HWDATA, HRDATA, PWDATA, PRDATA
- TIMEOUT_CYCLES, 16, ACCESS-state wait limit; used only with APB_TIMEOUT_EN

Ports:
- HCLK  in  1  single clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HTRANS  in  2  transfer type; a transfer is valid when HTRANS[1]=1 (NONSEQ/SEQ)
- HADDR  in  ADDR_WIDTH  address-phase address
- HWRITE  in  1  1=write, 0=read
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase
- HREADY  out  1  transfer done / address phase accepted
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  DATA_WIDTH  read data
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values: state=IDLE, HREADY=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled at the edge.
  - On accept, HADDR and HWRITE are latched into PADDR and PWRITE.
  - HSEL=0 or HTRANS=IDLE/BUSY is ignored; the bridge stays or returns to IDLE.
- States:
  - IDLE: HREADY=1, HRESP=0.
    - Accept read -> SETUP.
    - Accept write -> WLATCH.
  - WLATCH: HREADY=0. Capture HWDATA into PWDATA. -> SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADY=0. -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADY=0. Hold until PREADY=1.
    - PREADY=1 and PSLVERR=0: capture PRDATA into HRDATA (reads only); -> DONE.
    - PREADY=1 and PSLVERR=1: -> ERR1. HRDATA unchanged.
  - DONE: PSEL=0, PENABLE=0, HREADY=1, HRESP=0.
    - Accept in this cycle -> SETUP or WLATCH directly (back-to-back, no IDLE cycle).
    - Otherwise -> IDLE.
  - ERR1: HREADY=0, HRESP=1, PSEL=0. -> ERR2.
  - ERR2: HREADY=1, HRESP=1. Accept rules are the same as in DONE.
- Latency with zero APB wait states, address phase accepted at edge T:
  - Read: SETUP at T+1, ACCESS at T+2, DONE at T+3 with HRDATA valid.
  - Write: WLATCH at T+1, SETUP at T+2, ACCESS at T+3, DONE at T+4.
  - Each PREADY-low cycle adds one cycle.
- PADDR, PWRITE and PWDATA hold stable from SETUP through the end of ACCESS.
- PADDR and PWRITE keep their last values while idle. HRDATA holds its last read value until the next successful read.
- PSLVERR is ignored while PREADY=0.
- Reset asserted in any state takes effect at the next edge: reset values are restored and the in-flight transfer is dropped without a response.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: PSEL and PENABLE drop, and the FSM enters ERR1 (two-cycle ERROR response).
  - PREADY=1 in the same cycle the limit is reached takes priority, and the transfer completes normally.
- Undefined: no counter; ACCESS waits for PREADY indefinitely.

Test Plan:
1. Read HADDR=0x0010, PREADY=1, PRDATA=0xDEADBEEF -> PADDR=0x0010 and PSEL=1 at T+1, PENABLE=1 at T+2, HREADY=1 with HRDATA=0xDEADBEEF and HRESP=0 at T+3.
2. Write HADDR=0x0024, HWDATA=0xA5A50001, PREADY low for 2 cycles -> PWRITE=1, PWDATA=0xA5A50001 stable, PENABLE high for 3 cycles, HREADY=1 at T+6.
3. Read with PREADY=1, PSLVERR=1 -> ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1); HRDATA keeps its previous value.
4. Write 0x0004 completes and a read of 0x0008 is accepted in the DONE cycle -> PSEL=1 with PADDR=0x0008 on the very next cycle; PSEL goes low for exactly one cycle between the two transfers.
5. HRESET=1 during ACCESS -> at the next edge PSEL=0, PENABLE=0, HREADY=1, state IDLE. Next, HTRANS=2'b01 with HSEL=1 -> no APB activity.
6. PREADY held 0 -> with APB_TIMEOUT_EN, ERROR response after 16 ACCESS cycles; without the macro, PENABLE is still 1 after 100 cycles.
